// File: rtl/fpu_pkg.sv
// Shared constants and types for the coprocessor-1 register bank write scheduler.
package fpu_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    // Requester ids, also the encoding of the round-robin pointer.
    localparam logic REQ_FPU = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [NREGS-1:0]  busy_vec_t;

    // One-hot mask selecting a single scoreboard entry.
    function automatic busy_vec_t reg_onehot(input reg_addr_t r);
        return busy_vec_t'(1) << r;
    endfunction

endpackage

// File: rtl/fpu_regfile_write_scheduler_if.sv
// Request, issue, hazard-query and write-port signals of the write scheduler.
interface fpu_regfile_write_scheduler_if;
    import fpu_pkg::*;

    logic      iFlush;
    logic      iIssueValid;
    reg_addr_t iIssueReg;
    logic      oIssueReady;
    logic      iFpuValid;
    reg_addr_t iFpuReg;
    reg_data_t iFpuData;
    logic      oFpuReady;
    logic      iCpuValid;
    reg_addr_t iCpuReg;
    reg_data_t iCpuData;
    logic      oCpuReady;
    reg_addr_t iReadRegister1;
    reg_addr_t iReadRegister2;
    logic      oHazard;
    logic      oRegWrite;
    reg_addr_t oWriteRegister;
    reg_data_t oWriteData;
    busy_vec_t oBusy;

    // Requesters / control side.
    modport master (
        output iFlush, iIssueValid, iIssueReg,
        output iFpuValid, iFpuReg, iFpuData,
        output iCpuValid, iCpuReg, iCpuData,
        output iReadRegister1, iReadRegister2,
        input  oIssueReady, oFpuReady, oCpuReady, oHazard,
        input  oRegWrite, oWriteRegister, oWriteData, oBusy
    );

    // Scheduler side.
    modport slave (
        input  iFlush, iIssueValid, iIssueReg,
        input  iFpuValid, iFpuReg, iFpuData,
        input  iCpuValid, iCpuReg, iCpuData,
        input  iReadRegister1, iReadRegister2,
        output oIssueReady, oFpuReady, oCpuReady, oHazard,
        output oRegWrite, oWriteRegister, oWriteData, oBusy
    );

endinterface

// File: rtl/fpu_scoreboard.sv
// Per-register busy bits for in-flight FPU ops, with set/clear/flush and three read ports.
module fpu_scoreboard
    import fpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      set_en,
    input  reg_addr_t set_reg,
    input  logic      clr_en,
    input  reg_addr_t clr_reg,
    input  reg_addr_t rd_reg_a,
    input  reg_addr_t rd_reg_b,
    input  reg_addr_t rd_reg_c,
    output logic      rd_busy_a,
    output logic      rd_busy_b,
    output logic      rd_busy_c,
    output busy_vec_t busy
);

    busy_vec_t busy_q, busy_d;

    // Next busy vector: clear first so a same-register set wins; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~reg_onehot(clr_reg);
        end
        if (set_en) begin
            busy_d = busy_d | reg_onehot(set_reg);
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_busy_a = busy_q[rd_reg_a];
    assign rd_busy_b = busy_q[rd_reg_b];
    assign rd_busy_c = busy_q[rd_reg_c];
    assign busy      = busy_q;

endmodule

// File: rtl/fpu_regfile_write_scheduler.sv
// Arbitrates the single FP register bank write port between the FPU result path and
// the CPU transfer path, and tracks in-flight FPU destinations for hazard detection.
module fpu_regfile_write_scheduler
    import fpu_pkg::*;
#(
    parameter int unsigned FPU_PRIORITY = 0
) (
    input  logic                             iCLK,
    input  logic                             iRST_n,
    fpu_regfile_write_scheduler_if.slave     bus
);

    localparam bit FpuWins = (FPU_PRIORITY != 0);

    busy_vec_t busy;
    logic      issue_busy;
    logic      rd1_busy;
    logic      rd2_busy;
    logic      issue_fire;
    logic      cpu_eligible;
    logic      grant_fpu;
    logic      grant_cpu;
    logic      prio_q, prio_d;
    logic      reg_write_q;
    reg_addr_t write_reg_q;
    reg_data_t write_data_q;

    // An issue to a register that is still busy is dropped.
    assign issue_fire = bus.iIssueValid & ~issue_busy;

    fpu_scoreboard u_scoreboard (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .flush     (bus.iFlush),
        .set_en    (issue_fire),
        .set_reg   (bus.iIssueReg),
        .clr_en    (grant_fpu),
        .clr_reg   (bus.iFpuReg),
        .rd_reg_a  (bus.iIssueReg),
        .rd_reg_b  (bus.iReadRegister1),
        .rd_reg_c  (bus.iReadRegister2),
        .rd_busy_a (issue_busy),
        .rd_busy_b (rd1_busy),
        .rd_busy_c (rd2_busy),
        .busy      (busy)
    );

    // Grant selection: CPU must not overwrite a register an FPU op still owns (WAW).
    always_comb begin
        cpu_eligible = bus.iCpuValid & ~busy[bus.iCpuReg];
        grant_fpu    = 1'b0;
        grant_cpu    = 1'b0;
        if (bus.iFpuValid && cpu_eligible) begin
            if (FpuWins || (prio_q == REQ_FPU)) begin
                grant_fpu = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
        end else if (bus.iFpuValid) begin
            grant_fpu = 1'b1;
        end else if (cpu_eligible) begin
            grant_cpu = 1'b1;
        end
        prio_d = prio_q;
        if (grant_fpu) begin
            prio_d = REQ_CPU;
        end else if (grant_cpu) begin
            prio_d = REQ_FPU;
        end
    end

    // Round-robin pointer and registered write port.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            prio_q       <= REQ_FPU;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            prio_q      <= prio_d;
            reg_write_q <= grant_fpu | grant_cpu;
            if (grant_fpu) begin
                write_reg_q  <= bus.iFpuReg;
                write_data_q <= bus.iFpuData;
            end else if (grant_cpu) begin
                write_reg_q  <= bus.iCpuReg;
                write_data_q <= bus.iCpuData;
            end
        end
    end

    assign bus.oIssueReady    = ~issue_busy;
    assign bus.oFpuReady      = grant_fpu;
    assign bus.oCpuReady      = grant_cpu;
    assign bus.oHazard        = rd1_busy | rd2_busy;
    assign bus.oRegWrite      = reg_write_q;
    assign bus.oWriteRegister = write_reg_q;
    assign bus.oWriteData     = write_data_q;
    assign bus.oBusy          = busy;

endmodule

// File: tb/tb_fpu_regfile_write_scheduler.sv
// Directed bench for the FP register bank write scheduler (round-robin and FPU-priority builds).
module tb_fpu_regfile_write_scheduler;
    import fpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fpu_regfile_write_scheduler_if bus_rr ();
    fpu_regfile_write_scheduler_if bus_pr ();

    fpu_regfile_write_scheduler #(.FPU_PRIORITY(0)) dut_rr (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus_rr)
    );

    fpu_regfile_write_scheduler #(.FPU_PRIORITY(1)) dut_pr (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus_pr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_rr.iFlush = 1'b0; bus_rr.iIssueValid = 1'b0; bus_rr.iIssueReg = '0;
        bus_rr.iFpuValid = 1'b0; bus_rr.iFpuReg = '0; bus_rr.iFpuData = '0;
        bus_rr.iCpuValid = 1'b0; bus_rr.iCpuReg = '0; bus_rr.iCpuData = '0;
        bus_rr.iReadRegister1 = '0; bus_rr.iReadRegister2 = '0;
        bus_pr.iFlush = 1'b0; bus_pr.iIssueValid = 1'b0; bus_pr.iIssueReg = '0;
        bus_pr.iFpuValid = 1'b0; bus_pr.iFpuReg = '0; bus_pr.iFpuData = '0;
        bus_pr.iCpuValid = 1'b0; bus_pr.iCpuReg = '0; bus_pr.iCpuData = '0;
        bus_pr.iReadRegister1 = '0; bus_pr.iReadRegister2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b0) begin n_fail++;
            $display("FAIL reset_regwrite: got %0b want 0", bus_rr.oRegWrite); end
        n_checks++; if (bus_rr.oBusy !== 32'h0) begin n_fail++;
            $display("FAIL reset_busy: got %h want 00000000", bus_rr.oBusy); end
        n_checks++; if (bus_rr.oWriteRegister !== 5'd0 || bus_rr.oWriteData !== 32'h0) begin n_fail++;
            $display("FAIL reset_wport: got reg %0d data %h want 0/0", bus_rr.oWriteRegister,
                     bus_rr.oWriteData); end
        n_checks++; if (bus_pr.oRegWrite !== 1'b0 || bus_pr.oBusy !== 32'h0) begin n_fail++;
            $display("FAIL reset_pr: got wr %0b busy %h want 0/0", bus_pr.oRegWrite, bus_pr.oBusy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_write();
        bus_rr.iCpuValid = 1'b1; bus_rr.iCpuReg = 5'd5; bus_rr.iCpuData = 32'h3F80_0000;
        #1;
        n_checks++; if (bus_rr.oCpuReady !== 1'b1) begin n_fail++;
            $display("FAIL cpu_ready: got %0b want 1", bus_rr.oCpuReady); end
        tick();
        bus_rr.iCpuValid = 1'b0;
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd5
                        || bus_rr.oWriteData !== 32'h3F80_0000) begin n_fail++;
            $display("FAIL cpu_write: got wr %0b reg %0d data %h want 1/5/3f800000",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b0) begin n_fail++;
            $display("FAIL cpu_pulse: got %0b want 0", bus_rr.oRegWrite); end
    endtask

    task automatic test_conflict();
        bus_rr.iFpuValid = 1'b1; bus_rr.iFpuReg = 5'd2; bus_rr.iFpuData = 32'hAAAA_0002;
        bus_rr.iCpuValid = 1'b1; bus_rr.iCpuReg = 5'd3; bus_rr.iCpuData = 32'hBBBB_0003;
        bus_pr.iFpuValid = 1'b1; bus_pr.iFpuReg = 5'd2; bus_pr.iFpuData = 32'hAAAA_0002;
        bus_pr.iCpuValid = 1'b1; bus_pr.iCpuReg = 5'd3; bus_pr.iCpuData = 32'hBBBB_0003;
        #1;
        n_checks++; if (bus_rr.oFpuReady !== 1'b1 || bus_rr.oCpuReady !== 1'b0) begin n_fail++;
            $display("FAIL rr_first: got fpu %0b cpu %0b want 1/0", bus_rr.oFpuReady,
                     bus_rr.oCpuReady); end
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd2
                        || bus_rr.oWriteData !== 32'hAAAA_0002) begin n_fail++;
            $display("FAIL rr_write1: got wr %0b reg %0d data %h want 1/2/aaaa0002",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        n_checks++; if (bus_rr.oFpuReady !== 1'b0 || bus_rr.oCpuReady !== 1'b1) begin n_fail++;
            $display("FAIL rr_second: got fpu %0b cpu %0b want 0/1", bus_rr.oFpuReady,
                     bus_rr.oCpuReady); end
        n_checks++; if (bus_pr.oFpuReady !== 1'b1 || bus_pr.oCpuReady !== 1'b0) begin n_fail++;
            $display("FAIL pr_second: got fpu %0b cpu %0b want 1/0", bus_pr.oFpuReady,
                     bus_pr.oCpuReady); end
        tick();
        idle_inputs();
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd3
                        || bus_rr.oWriteData !== 32'hBBBB_0003) begin n_fail++;
            $display("FAIL rr_write2: got wr %0b reg %0d data %h want 1/3/bbbb0003",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        n_checks++; if (bus_pr.oRegWrite !== 1'b1 || bus_pr.oWriteRegister !== 5'd2
                        || bus_pr.oWriteData !== 32'hAAAA_0002) begin n_fail++;
            $display("FAIL pr_write2: got wr %0b reg %0d data %h want 1/2/aaaa0002",
                     bus_pr.oRegWrite, bus_pr.oWriteRegister, bus_pr.oWriteData); end
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b0) begin n_fail++;
            $display("FAIL rr_idle: got %0b want 0", bus_rr.oRegWrite); end
    endtask

    task automatic test_scoreboard();
        bus_rr.iIssueValid = 1'b1; bus_rr.iIssueReg = 5'd7;
        #1;
        n_checks++; if (bus_rr.oIssueReady !== 1'b1) begin n_fail++;
            $display("FAIL sb_issue_ready: got %0b want 1", bus_rr.oIssueReady); end
        tick();
        bus_rr.iIssueValid = 1'b0;
        bus_rr.iReadRegister1 = 5'd7;
        bus_rr.iCpuValid = 1'b1; bus_rr.iCpuReg = 5'd7; bus_rr.iCpuData = 32'hC0C0_0007;
        #1;
        n_checks++; if (bus_rr.oBusy !== 32'h0000_0080) begin n_fail++;
            $display("FAIL sb_busy7: got %h want 00000080", bus_rr.oBusy); end
        n_checks++; if (bus_rr.oIssueReady !== 1'b0) begin n_fail++;
            $display("FAIL sb_issue_blocked: got %0b want 0", bus_rr.oIssueReady); end
        n_checks++; if (bus_rr.oHazard !== 1'b1) begin n_fail++;
            $display("FAIL sb_hazard1: got %0b want 1", bus_rr.oHazard); end
        n_checks++; if (bus_rr.oCpuReady !== 1'b0) begin n_fail++;
            $display("FAIL sb_cpu_waw: got %0b want 0", bus_rr.oCpuReady); end
        bus_rr.iReadRegister1 = 5'd1; bus_rr.iReadRegister2 = 5'd7;
        #1;
        n_checks++; if (bus_rr.oHazard !== 1'b1) begin n_fail++;
            $display("FAIL sb_hazard2: got %0b want 1", bus_rr.oHazard); end
        bus_rr.iReadRegister2 = 5'd6;
        #1;
        n_checks++; if (bus_rr.oHazard !== 1'b0) begin n_fail++;
            $display("FAIL sb_nohazard: got %0b want 0", bus_rr.oHazard); end
        bus_rr.iReadRegister1 = 5'd7;
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b0) begin n_fail++;
            $display("FAIL sb_cpu_held: got %0b want 0", bus_rr.oRegWrite); end
        bus_rr.iFpuValid = 1'b1; bus_rr.iFpuReg = 5'd7; bus_rr.iFpuData = 32'hD0D0_0007;
        #1;
        n_checks++; if (bus_rr.oFpuReady !== 1'b1 || bus_rr.oCpuReady !== 1'b0) begin n_fail++;
            $display("FAIL sb_fpu_grant: got fpu %0b cpu %0b want 1/0", bus_rr.oFpuReady,
                     bus_rr.oCpuReady); end
        tick();
        bus_rr.iFpuValid = 1'b0;
        #1;
        n_checks++; if (bus_rr.oBusy !== 32'h0 || bus_rr.oHazard !== 1'b0) begin n_fail++;
            $display("FAIL sb_clear: got busy %h hazard %0b want 0/0", bus_rr.oBusy,
                     bus_rr.oHazard); end
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteData !== 32'hD0D0_0007) begin
            n_fail++;
            $display("FAIL sb_fpu_write: got wr %0b data %h want 1/d0d00007", bus_rr.oRegWrite,
                     bus_rr.oWriteData); end
        n_checks++; if (bus_rr.oCpuReady !== 1'b1) begin n_fail++;
            $display("FAIL sb_cpu_release: got %0b want 1", bus_rr.oCpuReady); end
        tick();
        idle_inputs();
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd7
                        || bus_rr.oWriteData !== 32'hC0C0_0007) begin n_fail++;
            $display("FAIL sb_cpu_write: got wr %0b reg %0d data %h want 1/7/c0c00007",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        tick();
    endtask

    task automatic test_set_clear_same();
        bus_rr.iIssueValid = 1'b1; bus_rr.iIssueReg = 5'd4;
        bus_rr.iFpuValid = 1'b1; bus_rr.iFpuReg = 5'd4; bus_rr.iFpuData = 32'h4040_0000;
        #1;
        n_checks++; if (bus_rr.oIssueReady !== 1'b1 || bus_rr.oFpuReady !== 1'b1) begin n_fail++;
            $display("FAIL sc_ready: got issue %0b fpu %0b want 1/1", bus_rr.oIssueReady,
                     bus_rr.oFpuReady); end
        tick();
        bus_rr.iIssueValid = 1'b0;
        bus_rr.iFpuValid = 1'b0;
        n_checks++; if (bus_rr.oBusy !== 32'h0000_0010) begin n_fail++;
            $display("FAIL sc_set_wins: got %h want 00000010", bus_rr.oBusy); end
        bus_rr.iFpuValid = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (bus_rr.oBusy !== 32'h0) begin n_fail++;
            $display("FAIL sc_cleared: got %h want 00000000", bus_rr.oBusy); end
        tick();
    endtask

    task automatic test_flush();
        bus_rr.iIssueValid = 1'b1; bus_rr.iIssueReg = 5'd0;
        tick();
        bus_rr.iIssueReg = 5'd7;
        tick();
        bus_rr.iIssueValid = 1'b0;
        n_checks++; if (bus_rr.oBusy !== 32'h0000_0081) begin n_fail++;
            $display("FAIL fl_pre: got %h want 00000081", bus_rr.oBusy); end
        bus_rr.iFlush = 1'b1;
        bus_rr.iIssueValid = 1'b1; bus_rr.iIssueReg = 5'd9;
        bus_rr.iFpuValid = 1'b1; bus_rr.iFpuReg = 5'd1; bus_rr.iFpuData = 32'hEEEE_0001;
        bus_rr.iCpuValid = 1'b1; bus_rr.iCpuReg = 5'd0; bus_rr.iCpuData = 32'h1234_5678;
        #1;
        n_checks++; if (bus_rr.oCpuReady !== 1'b0) begin n_fail++;
            $display("FAIL fl_cpu_blocked: got %0b want 0", bus_rr.oCpuReady); end
        tick();
        bus_rr.iFlush = 1'b0; bus_rr.iIssueValid = 1'b0; bus_rr.iFpuValid = 1'b0;
        #1;
        n_checks++; if (bus_rr.oBusy !== 32'h0) begin n_fail++;
            $display("FAIL fl_busy: got %h want 00000000", bus_rr.oBusy); end
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd1
                        || bus_rr.oWriteData !== 32'hEEEE_0001) begin n_fail++;
            $display("FAIL fl_grant_write: got wr %0b reg %0d data %h want 1/1/eeee0001",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        n_checks++; if (bus_rr.oCpuReady !== 1'b1) begin n_fail++;
            $display("FAIL fl_cpu_accept: got %0b want 1", bus_rr.oCpuReady); end
        tick();
        idle_inputs();
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oWriteRegister !== 5'd0
                        || bus_rr.oWriteData !== 32'h1234_5678) begin n_fail++;
            $display("FAIL fl_cpu_write: got wr %0b reg %0d data %h want 1/0/12345678",
                     bus_rr.oRegWrite, bus_rr.oWriteRegister, bus_rr.oWriteData); end
        tick();
    endtask

    task automatic test_reset_midrun();
        bus_rr.iIssueValid = 1'b1; bus_rr.iIssueReg = 5'd3;
        bus_rr.iCpuValid = 1'b1; bus_rr.iCpuReg = 5'd6; bus_rr.iCpuData = 32'hF00D_0006;
        tick();
        idle_inputs();
        n_checks++; if (bus_rr.oRegWrite !== 1'b1 || bus_rr.oBusy !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL mr_pre: got wr %0b busy %h want 1/00000008", bus_rr.oRegWrite,
                     bus_rr.oBusy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_rr.oRegWrite !== 1'b0 || bus_rr.oBusy !== 32'h0) begin n_fail++;
            $display("FAIL mr_async: got wr %0b busy %h want 0/0", bus_rr.oRegWrite,
                     bus_rr.oBusy); end
        n_checks++; if (bus_rr.oWriteRegister !== 5'd0 || bus_rr.oWriteData !== 32'h0) begin
            n_fail++;
            $display("FAIL mr_wport: got reg %0d data %h want 0/0", bus_rr.oWriteRegister,
                     bus_rr.oWriteData); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus_rr.oRegWrite !== 1'b0) begin n_fail++;
            $display("FAIL mr_after: got %0b want 0", bus_rr.oRegWrite); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_cpu_write();
        test_conflict();
        test_scoreboard();
        test_set_clear_same();
        test_flush();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
